// File: rtl/seg_scan_decoder_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
// Pulls in the common glyph set and defines the classification of a
// synchronized digit-enable word.
package seg_scan_decoder_pkg;

  `include "seg_patterns.vh"

  // How many digit enables are low in the synchronized sample.
  typedef enum logic [1:0] {
    ScanIdle,   // none: display blanked between digits
    ScanOne,    // exactly one: a capturable dwell
    ScanMulti   // two or more: driver fault
  } scan_e;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bus between the display being observed and the scan decoder.
// master: drives segments/digit/clear_err, observes the decoded results.
// slave : the decoder; samples segments/digit/clear_err, drives
//         value/known/frame_valid/bad_pattern/collision.
interface seg_scan_decoder_if #(
  parameter int unsigned NDIG = 8
);
  logic [6:0]        segments;     // active-low pattern, A..G
  logic [NDIG-1:0]   digit;        // active-low digit enables
  logic              clear_err;    // synchronous clear of sticky flags
  logic [4*NDIG-1:0] value;        // decoded nibble per position
  logic [NDIG-1:0]   known;        // last capture per position was a glyph
  logic              frame_valid;  // every position captured since last pulse
  logic              bad_pattern;  // sticky: lit non-hex pattern seen
  logic              collision;    // sticky: several digits enabled at once

  modport master (
    output segments, digit, clear_err,
    input  value, known, frame_valid, bad_pattern, collision
  );

  modport slave (
    input  segments, digit, clear_err,
    output value, known, frame_valid, bad_pattern, collision
  );
endinterface

// File: rtl/seg2hex.sv
// Combinational decode of an active-low seven-segment pattern to a nibble.
// Ports:
//   pattern  - 7-bit pattern, bit 6 = A .. bit 0 = G, active low
//   nibble   - decoded value, 0 when the pattern is not a glyph
//   is_hex   - pattern matches one of the 16 hex glyphs
//   is_blank - pattern is all segments off
module seg2hex
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_blank
);

  always_comb begin
    nibble = '0;
    is_hex = 1'b0;
    for (int unsigned g = 0; g < 16; g++) begin
      if (pattern == SegGlyph[g]) begin
        nibble = 4'(g);
        is_hex = 1'b1;
      end
    end
  end

  assign is_blank = (pattern == SegBlank);

endmodule

// File: rtl/seg_patterns.vh
// Seven-segment glyph set shared by the display encoder and the scan decoder.
// Patterns are active low, bit 6 = segment A down to bit 0 = segment G.
// Entry n of SegGlyph is the glyph for nibble n; SegBlank is the unlit pattern.
`ifndef SEG_PATTERNS_VH
`define SEG_PATTERNS_VH

localparam logic [6:0] SegGlyph [16] = '{
  7'b0000001,  // 0
  7'b1001111,  // 1
  7'b0010010,  // 2
  7'b0000110,  // 3
  7'b1001100,  // 4
  7'b0100100,  // 5
  7'b0100000,  // 6
  7'b0001111,  // 7
  7'b0000000,  // 8
  7'b0000100,  // 9
  7'b0001000,  // A
  7'b1100000,  // b
  7'b0110001,  // C
  7'b1000010,  // d
  7'b0110000,  // E
  7'b0111000   // F
};

localparam logic [6:0] SegBlank = 7'b1111111;

`endif

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed seven-segment display. Synchronizes the
// segment and digit-enable lines, waits for each digit dwell to hold for
// SETTLE cycles, decodes the pattern and stores it per position.
// Ports:
//   clock   - system clock
//   reset_n - asynchronous active-low reset
//   bus     - slave side of seg_scan_decoder_if (inputs from the display,
//             decoded value/known, frame_valid pulse, sticky flags)
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int unsigned NDIG   = 8,
  parameter int unsigned SETTLE = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  seg_scan_decoder_if.slave bus
);

  localparam int unsigned SW   = NDIG + 7;
  localparam int unsigned CntW = $clog2(SETTLE + 1);
  localparam logic [CntW-1:0] SettleC  = CntW'(SETTLE);
  localparam logic [CntW-1:0] SettleM1 = CntW'(SETTLE - 1);

  // Two-stage synchronizer; reset to all ones (nothing lit).
  logic [SW-1:0] s1_q, s2_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= {bus.digit, bus.segments};
      s2_q <= s1_q;
    end
  end

  logic            stable;
  logic [NDIG-1:0] digit_low;
  logic [6:0]      seg_s2;

  assign stable    = (s1_q == s2_q);
  assign digit_low = ~s2_q[SW-1:7];
  assign seg_s2    = s2_q[6:0];

  // Stability counter; saturating at SETTLE is what limits each dwell to
  // a single capture.
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!stable) begin
      cnt_d = '0;
    end else if (cnt_q < SettleC) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  scan_e scan;

  always_comb begin
    if (digit_low == '0) begin
      scan = ScanIdle;
    end else if ((digit_low & (digit_low - NDIG'(1))) == '0) begin
      scan = ScanOne;
    end else begin
      scan = ScanMulti;
    end
  end

  logic settle_hit, capture, multi_hit;

  assign settle_hit = stable && (cnt_q == SettleM1);
  assign capture    = settle_hit && (scan == ScanOne);
  assign multi_hit  = settle_hit && (scan == ScanMulti);

  logic [3:0] nibble;
  logic       is_hex, is_blank;

  seg2hex u_seg2hex (
    .pattern  (seg_s2),
    .nibble   (nibble),
    .is_hex   (is_hex),
    .is_blank (is_blank)
  );

  logic [4*NDIG-1:0] value_q, value_d;
  logic [NDIG-1:0]   known_q, known_d;
  logic [NDIG-1:0]   seen_q, seen_d, seen_next;
  logic              frame_q, frame_d;
  logic              bad_q, bad_d;
  logic              coll_q, coll_d;

  always_comb begin
    value_d   = value_q;
    known_d   = known_q;
    seen_d    = seen_q;
    seen_next = seen_q;
    frame_d   = 1'b0;
    // Clear first so a coincident set below takes priority.
    bad_d     = bus.clear_err ? 1'b0 : bad_q;
    coll_d    = bus.clear_err ? 1'b0 : coll_q;

    if (capture) begin
      // digit_low is one-hot here, so it doubles as the position select.
      for (int i = 0; i < int'(NDIG); i++) begin
        if (digit_low[i]) begin
          if (is_hex) begin
            value_d[4*i +: 4] = nibble;
          end
          known_d[i] = is_hex;
        end
      end
      seen_next = seen_q | digit_low;
      if (&seen_next) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end else begin
        seen_d  = seen_next;
      end
      if (!is_hex && !is_blank) begin
        bad_d = 1'b1;
      end
    end

    if (multi_hit) begin
      coll_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      value_q <= '0;
      known_q <= '0;
      seen_q  <= '0;
      frame_q <= 1'b0;
      bad_q   <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      value_q <= value_d;
      known_q <= known_d;
      seen_q  <= seen_d;
      frame_q <= frame_d;
      bad_q   <= bad_d;
      coll_q  <= coll_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.known       = known_q;
  assign bus.frame_valid = frame_q;
  assign bus.bad_pattern = bad_q;
  assign bus.collision   = coll_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus random
// dwells, checked against a dwell-level reference model. Frame completions
// are queued as expected results and compared by a separate monitor.
module tb_seg_scan_decoder;

  localparam int unsigned NDIG   = 8;
  localparam int unsigned SETTLE = 4;

  localparam logic [6:0] Glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  seg_scan_decoder_if #(.NDIG(NDIG)) bus ();

  seg_scan_decoder #(
    .NDIG   (NDIG),
    .SETTLE (SETTLE)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] val;
    logic [7:0]  kn;
    logic        bad;
    logic        coll;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic [3:0] m_val [8];
  logic [7:0] m_known;
  logic [7:0] m_seen;
  logic       m_bad;
  logic       m_coll;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] m_pack();
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = m_val[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_val[i] = 4'h0;
    m_known = '0;
    m_seen  = '0;
    m_bad   = 1'b0;
    m_coll  = 1'b0;
  endtask

  // A dwell held for len edges is captured once it lasts SETTLE+1 edges.
  task automatic model_apply(input logic [7:0] dig, input logic [6:0] seg, input int len);
    int   nlow;
    int   pos;
    int   g;
    exp_t e;
    nlow = 0;
    pos  = 0;
    g    = -1;
    if (len < int'(SETTLE) + 1) return;
    for (int i = 0; i < 8; i++) begin
      if (!dig[i]) begin
        nlow++;
        pos = i;
      end
    end
    if (nlow == 0) return;
    if (nlow > 1) begin
      m_coll = 1'b1;
      return;
    end
    for (int k = 0; k < 16; k++) if (seg == Glyph[k]) g = k;
    if (g >= 0) begin
      m_val[pos]   = 4'(g);
      m_known[pos] = 1'b1;
    end else begin
      m_known[pos] = 1'b0;
      if (seg != 7'h7F) m_bad = 1'b1;
    end
    m_seen[pos] = 1'b1;
    if (m_seen == 8'hFF) begin
      e.val  = m_pack();
      e.kn   = m_known;
      e.bad  = m_bad;
      e.coll = m_coll;
      exp_q.push_back(e);
      m_seen = '0;
    end
  endtask

  task automatic drive(input logic [7:0] dig, input logic [6:0] seg);
    bus.digit    = dig;
    bus.segments = seg;
  endtask

  // Called at a falling edge; holds the pattern for len rising edges, then
  // blanks the display for gap edges so every dwell starts a fresh count.
  task automatic dwell(input logic [7:0] dig, input logic [6:0] seg, input int len,
                       input int gap);
    drive(dig, seg);
    model_apply(dig, seg, len);
    repeat (len) @(negedge clock);
    drive(8'hFF, 7'h7F);
    repeat (gap) @(negedge clock);
  endtask

  task automatic pulse_clear();
    bus.clear_err = 1'b1;
    @(negedge clock);
    bus.clear_err = 1'b0;
    m_bad  = 1'b0;
    m_coll = 1'b0;
  endtask

  // Monitor: each frame_valid pulse must match the oldest expected frame.
  always @(negedge clock) begin
    exp_t e;
    exp_t got;
    if (reset_n && bus.frame_valid) begin
      got.val  = bus.value;
      got.kn   = bus.known;
      got.bad  = bus.bad_pattern;
      got.coll = bus.collision;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_pulse: unexpected pulse with value=%h known=%h, none expected",
                 bus.value, bus.known);
      end else begin
        e = exp_q.pop_front();
        check("frame_result", 64'(got), 64'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dig;
    logic [6:0] seg;
    int         pos, other, kind, len, gap;

    bus.digit     = '1;
    bus.segments  = '1;
    bus.clear_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);

    check("reset_value", bus.value, 0);
    check("reset_known", bus.known, 0);
    check("reset_frame", bus.frame_valid, 0);
    check("reset_bad", bus.bad_pattern, 0);
    check("reset_coll", bus.collision, 0);

    reset_n = 1'b1;
    @(negedge clock);

    // Single digit: capture lands on edge SETTLE+2.
    drive(8'hFE, 7'b0010010);
    model_apply(8'hFE, 7'b0010010, 10);
    repeat (SETTLE + 1) @(negedge clock);
    check("latency_early_known", bus.known[0], 0);
    @(negedge clock);
    check("single_value", bus.value[3:0], 2);
    check("single_known", bus.known[0], 1);
    repeat (4) @(negedge clock);
    drive(8'hFF, 7'h7F);
    repeat (2) @(negedge clock);

    // Two full scans showing 1..8.
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < 8; p++) begin
        dig = ~(8'b1 << p);
        dwell(dig, Glyph[p + 1], 8, 2);
      end
      check("scan_value", bus.value, 32'h87654321);
      check("scan_known", bus.known, 8'hFF);
    end

    // Glitch shorter than the settle window.
    dwell(8'hFD, 7'b0000000, 3, 8);
    check("glitch_value", bus.value, m_pack());
    check("glitch_known", bus.known, m_known);

    // Error flags.
    dwell(8'hFB, 7'b1111110, 8, 2);
    check("bad_set", bus.bad_pattern, 1);
    check("bad_known", bus.known[2], 0);
    dwell(8'hF3, 7'b0000001, 8, 2);
    check("coll_set", bus.collision, 1);
    pulse_clear();
    check("bad_cleared", bus.bad_pattern, 0);
    check("coll_cleared", bus.collision, 0);

    // Clear coinciding with a new bad capture: set wins.
    drive(8'hFB, 7'b1111110);
    model_apply(8'hFB, 7'b1111110, 8);
    repeat (SETTLE + 1) @(negedge clock);
    bus.clear_err = 1'b1;
    @(negedge clock);
    bus.clear_err = 1'b0;
    check("set_beats_clear", bus.bad_pattern, 1);
    repeat (2) @(negedge clock);
    drive(8'hFF, 7'h7F);
    repeat (2) @(negedge clock);

    // Blank is not an error.
    pulse_clear();
    dwell(8'hFE, 7'h7F, 8, 2);
    check("blank_known", bus.known[0], 0);
    check("blank_bad", bus.bad_pattern, 0);

    // Reset mid-dwell acts without a clock edge.
    drive(8'hF7, Glyph[5]);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("areset_value", bus.value, 0);
    check("areset_known", bus.known, 0);
    check("areset_frame", bus.frame_valid, 0);
    check("areset_bad", bus.bad_pattern, 0);
    check("areset_coll", bus.collision, 0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_apply(8'hF7, Glyph[5], 10);
    repeat (SETTLE + 1) @(negedge clock);
    check("post_reset_early", bus.known[3], 0);
    @(negedge clock);
    check("post_reset_known", bus.known[3], 1);
    check("post_reset_value", bus.value[15:12], 5);
    repeat (4) @(negedge clock);
    drive(8'hFF, 7'h7F);
    repeat (2) @(negedge clock);

    // Random dwells, lengths straddling the capture threshold.
    repeat (250) begin
      pos  = int'($urandom_range(0, 7));
      kind = int'($urandom_range(0, 9));
      gap  = int'($urandom_range(1, 3));
      if ($urandom_range(0, 3) != 0) len = int'($urandom_range(SETTLE + 1, SETTLE + 6));
      else len = int'($urandom_range(1, SETTLE + 1));
      dig = ~(8'b1 << pos);
      if (kind <= 5) begin
        seg = Glyph[$urandom_range(0, 15)];
      end else if (kind == 6) begin
        seg = 7'h7F;
      end else if (kind == 7) begin
        seg = 7'($urandom);
      end else if (kind == 8) begin
        other = (pos + int'($urandom_range(1, 7))) % 8;
        dig   = ~((8'b1 << pos) | (8'b1 << other));
        seg   = Glyph[$urandom_range(0, 15)];
      end else begin
        dig = 8'hFF;
        seg = Glyph[$urandom_range(0, 15)];
      end
      dwell(dig, seg, len, gap);
      if ($urandom_range(0, 15) == 0) pulse_clear();
    end

    repeat (10) @(negedge clock);
    check("final_value", bus.value, m_pack());
    check("final_known", bus.known, m_known);
    check("final_bad", bus.bad_pattern, m_bad);
    check("final_coll", bus.collision, m_coll);
    check("pending_frames", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
